stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 130 +++++++++++++
 tb/tb_stack_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - LIFO stack controller over an external 256x8 combinational-read RAM
//
// Purpose:
//   Keeps an occupancy count of 0..DEPTH. It drives the RAM port so that bytes are
//   pushed at BASE_ADDR+count and popped from BASE_ADDR+count-1 (both mod 256).
//   A push and a pop in the same cycle replace the top-of-stack entry.
//
// Parameters:
//   BASE_ADDR  first RAM address of the stack region (default 8'hC0)
//   DEPTH      stack capacity in bytes, 1..256-BASE_ADDR (default 64)
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   push, pop            stack requests, sampled on each rising edge
//   push_data            byte to push (also driven on ram_din in every cycle)
//   clr_err              clears the sticky ovf/unf flags
//   pop_data, pop_valid  registered popped byte and its one-cycle strobe
//   full, empty          combinational decodes of the occupancy count
//   ovf, unf             sticky overflow / underflow flags
//   ram_rw, ram_addr,    RAM write enable (1 = write), address and write data
//   ram_din
//   ram_dout             RAM combinational read data
//
// Configuration:
//   STACK_ERR_FLAGS_EN   when defined, ovf/unf are sticky error flags that clr_err
//                        clears; otherwise both are tied to 0 and clr_err is ignored.

module stack_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         DEPTH     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    input  logic       clr_err,
    output logic [7:0] pop_data,
    output logic       pop_valid,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic       unf,
    output logic       ram_rw,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout
);

    // The count needs nine bits because DEPTH can be as large as 256.
    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    logic [8:0] count;
    logic [7:0] wr_ptr;
    logic [7:0] top;
    logic       do_push;
    logic       do_pop;
    logic       do_repl;

    // Both pointers wrap mod 256. wr_ptr is used only while the stack is not full,
    // so it never leaves the stack region.
    assign wr_ptr = BASE_ADDR + count[7:0];
    assign top    = wr_ptr - 8'd1;

    assign full  = (count == DEPTH_C);
    assign empty = (count == 9'd0);

    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_repl = 1'b0;
        // If push and pop arrive together while the stack is empty, the request is
        // handled as a plain push.
        if (push && (!pop || empty) && !full)
            do_push = 1'b1;
        if (pop && !push && !empty)
            do_pop = 1'b1;
        if (push && pop && !empty)
            do_repl = 1'b1;
    end

    // The write enable is gated by rst_n. This keeps the RAM from being written
    // while reset is held, and it cancels a push if reset arrives mid-cycle.
    assign ram_rw   = rst_n & (do_push | do_repl);
    assign ram_addr = do_push ? wr_ptr : (empty ? BASE_ADDR : top);
    assign ram_din  = push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 9'd0;
            pop_data  <= 8'h00;
            pop_valid <= 1'b0;
        end else begin
            if (do_push)
                count <= count + 9'd1;
            else if (do_pop)
                count <= count - 9'd1;
            // A replace returns the old top byte, which the RAM still shows this cycle.
            pop_valid <= do_pop | do_repl;
            if (do_pop || do_repl)
                pop_data <= ram_dout;
        end
    end

`ifdef STACK_ERR_FLAGS_EN
    logic ovf_evt;
    logic unf_evt;

    assign ovf_evt = push & ~pop & full;
    assign unf_evt = pop & ~push & empty;

    // A new error event takes priority over clr_err in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf_evt | (ovf & ~clr_err);
            unf <= unf_evt | (unf & ~clr_err);
        end
    end
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign ovf            = 1'b0;
    assign unf            = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - self-checking bench for stack_ctrl with queue reference model
module tb_stack_ctrl;

    localparam logic [7:0] BASE  = 8'hC0;
    localparam int         DEPTH = 64;
`ifdef STACK_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       clr_err = 1'b0;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       ram_rw;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [0:255];

    stack_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
        .clr_err(clr_err), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
        .empty(empty), .ovf(ovf), .unf(unf), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];
    always @(posedge clk) if (ram_rw) mem[ram_addr] <= ram_din;

    // Reference model state
    logic [7:0] q [$];
    logic [7:0] m_pd;
    logic       m_pv;
    logic       m_ovf;
    logic       m_unf;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sets the inputs (the caller is at posedge+1) and checks the combinational outputs at the negedge.
    task automatic drive(input logic p, input logic o, input logic [7:0] d, input logic c);
        int   sz;
        logic e_rw;
        logic e_chk_addr;
        logic [7:0] e_addr;
        push = p; pop = o; push_data = d; clr_err = c;
        sz = q.size();
        e_rw = 1'b0;
        e_chk_addr = 1'b1;
        e_addr = (sz > 0) ? 8'(int'(BASE) + sz - 1) : BASE;
        if (p && !o) begin
            if (sz < DEPTH) begin e_rw = 1'b1; e_addr = 8'(int'(BASE) + sz); end
            else e_chk_addr = 1'b0;
        end else if (o && !p) begin
            if (sz == 0) e_chk_addr = 1'b0;
        end else if (p && o) begin
            e_rw = 1'b1;
        end
        #4;
        chk("ram_rw", ram_rw, e_rw);
        if (e_chk_addr) chk("ram_addr", ram_addr, e_addr);
        chk("ram_din", ram_din, d);
        chk("full_pre", full, sz == DEPTH);
        chk("empty_pre", empty, sz == 0);
    endtask

    // Lets the edge happen, updates the model, and checks the registered outputs.
    task automatic edge_check();
        int sz;
        logic ev_o;
        logic ev_u;
        sz = q.size();
        ev_o = 1'b0; ev_u = 1'b0; m_pv = 1'b0;
        if (push && !pop) begin
            if (sz < DEPTH) q.push_back(push_data); else ev_o = 1'b1;
        end else if (pop && !push) begin
            if (sz > 0) begin m_pd = q.pop_back(); m_pv = 1'b1; end else ev_u = 1'b1;
        end else if (push && pop) begin
            if (sz > 0) begin m_pd = q[$]; q[$] = push_data; m_pv = 1'b1; end
            else q.push_back(push_data);
        end
        m_ovf = ev_o | (m_ovf & ~clr_err);
        m_unf = ev_u | (m_unf & ~clr_err);
        @(posedge clk);
        #1;
        chk("pop_valid", pop_valid, m_pv);
        chk("pop_data", pop_data, m_pd);
        chk("ovf", ovf, FLAGS & m_ovf);
        chk("unf", unf, FLAGS & m_unf);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
    endtask

    task automatic step(input logic p, input logic o, input logic [7:0] d, input logic c);
        drive(p, o, d, c);
        edge_check();
    endtask

    typedef struct {
        logic       p;
        logic       o;
        logic [7:0] d;
        logic       c;
        logic       e_rw;
        logic [7:0] e_addr;
        logic       e_pv;
        logic [7:0] e_pd;
        logic       e_empty;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [7:0] wa;
        logic [7:0] saved;
        int r;
        logic rp;
        logic ro;

        tbl[0]  = '{1, 0, 8'hA1, 0, 1, 8'hC0, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 8'hB2, 0, 1, 8'hC1, 0, 8'h00, 0};
        tbl[2]  = '{1, 0, 8'hC3, 0, 1, 8'hC2, 0, 8'h00, 0};
        tbl[3]  = '{0, 0, 8'h44, 0, 0, 8'hC2, 0, 8'h00, 0};
        tbl[4]  = '{0, 1, 8'h00, 0, 0, 8'hC2, 1, 8'hC3, 0};
        tbl[5]  = '{0, 1, 8'h00, 0, 0, 8'hC1, 1, 8'hB2, 0};
        tbl[6]  = '{0, 1, 8'h00, 0, 0, 8'hC0, 1, 8'hA1, 1};
        tbl[7]  = '{0, 0, 8'h55, 0, 0, 8'hC0, 0, 8'hA1, 1};
        tbl[8]  = '{1, 0, 8'h11, 0, 1, 8'hC0, 0, 8'hA1, 0};
        tbl[9]  = '{1, 1, 8'h22, 0, 1, 8'hC0, 1, 8'h11, 0};
        tbl[10] = '{0, 1, 8'h00, 0, 0, 8'hC0, 1, 8'h22, 1};
        tbl[11] = '{0, 1, 8'h00, 0, 0, 8'hC0, 0, 8'h22, 1};
        tbl[12] = '{1, 1, 8'h33, 0, 1, 8'hC0, 0, 8'h22, 0};
        tbl[13] = '{0, 1, 8'h00, 0, 0, 8'hC0, 1, 8'h33, 1};
        tbl[14] = '{0, 0, 8'h00, 1, 0, 8'hC0, 0, 8'h33, 1};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        m_pd = 8'h00; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset state
        #2;
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        chk("rst_ram_rw", ram_rw, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].p, tbl[i].o, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_rw", i), ram_rw, tbl[i].e_rw);
            chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].e_addr);
            edge_check();
            chk($sformatf("tbl%0d_pv", i), pop_valid, tbl[i].e_pv);
            chk($sformatf("tbl%0d_pd", i), pop_data, tbl[i].e_pd);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
        end
        chk("mem_c0_replaced", mem[8'hC0], 8'h33);

        // Fill to capacity, then overflow and clr_err (including error-wins-over-clear)
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i + 8'h80), 0);
        chk("full_after_fill", full, 1);
        step(1, 0, 8'hFF, 0);
        chk("ovf_set", ovf, FLAGS);
        step(1, 0, 8'hFF, 1);
        chk("ovf_err_wins", ovf, FLAGS);
        step(0, 0, 8'h00, 1);
        chk("ovf_cleared", ovf, 0);
        chk("mem_00_untouched", mem[8'h00], 8'h5A);
        step(1, 1, 8'hEE, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0);
        chk("empty_after_drain", empty, 1);

        // Randomised traffic against the model
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 200; k++) begin
                r = $urandom_range(0, 99);
                if (ph % 2 == 0) begin rp = (r < 70); ro = (r >= 55); end
                else begin rp = (r < 30); ro = (r >= 15); end
                step(rp, ro, 8'($urandom), ($urandom_range(0, 7) == 0));
            end
        end

        // Reset in the middle of a push
        step(1, 0, 8'h91, 0);
        step(1, 0, 8'h92, 0);
        step(0, 1, 8'h00, 0);
        push = 1'b1; pop = 1'b0; push_data = 8'h77; clr_err = 1'b0;
        wa = 8'(int'(BASE) + q.size());
        saved = mem[wa];
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pop_valid", pop_valid, 0);
        chk("midrst_pop_data", pop_data, 8'h00);
        chk("midrst_empty", empty, 1);
        chk("midrst_ram_rw", ram_rw, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_unf", unf, 0);
        @(posedge clk); #1;
        chk("midrst_no_write", mem[wa], saved);
        push = 1'b0;
        #2;
        rst_n = 1'b1;
        q.delete(); m_pd = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk); #1;
        drive(1, 0, 8'h5A, 0);
        chk("postrst_addr", ram_addr, 8'hC0);
        edge_check();
        step(0, 1, 8'h00, 0);
        chk("postrst_pop", pop_data, 8'h5A);

        // Nothing outside the stack region may have been written
        begin
            int bad = 0;
            for (int i = 0; i < int'(BASE); i++) if (mem[i] !== (8'(i) ^ 8'h5A)) bad++;
            chk("outside_region_writes", bad, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
